// File: rtl/anc_pkg.sv
// Shared definitions for the noise-cancelling signal path.
//   SAMPLE_W          : sample width in bits
//   SAT_MAX / SAT_MIN : signed saturation limits for a sample
//   ATTEN_NUM/DEN     : forward attenuation coefficients (gain restore uses them swapped)
//   state_t           : handshake/datapath FSM states
package anc_pkg;

  localparam int unsigned SAMPLE_W = 16;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  localparam int unsigned ATTEN_NUM = 26123;
  localparam int unsigned ATTEN_DEN = 32767;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    SAT,
    HOLD
  } state_t;

endpackage

// File: rtl/restoring_div_u.sv
// Unsigned iterative restoring divider, one quotient bit per clock.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : load dividend/divisor and begin (single-cycle pulse)
//   dividend  : N_W-bit unsigned numerator
//   divisor   : D_W-bit unsigned, nonzero denominator
//   done      : high during the final iteration cycle; quotient is valid
//               from the following cycle until the next start
//   quotient  : N_W-bit unsigned result
module restoring_div_u #(
  parameter int unsigned N_W = 30,
  parameter int unsigned D_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           done,
  output logic [N_W-1:0] quotient
);

  localparam int unsigned C_W = (N_W > 1) ? $clog2(N_W) : 1;

  logic [N_W-1:0] num;
  logic [D_W-1:0] rem;
  logic [D_W-1:0] dvs;
  logic [C_W-1:0] cnt;
  logic           busy;

  logic [D_W:0]   trial;
  logic           ge;
  logic [D_W-1:0] rem_next;

  always_comb begin
    trial    = {rem, num[N_W-1]};
    ge       = (trial >= {1'b0, dvs});
    rem_next = ge ? D_W'(trial - {1'b0, dvs}) : trial[D_W-1:0];
  end

  // done is combinational so the caller can leave its wait state on the
  // same edge that retires the last quotient bit.
  assign done = busy && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num      <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      num      <= dividend;
      rem      <= '0;
      dvs      <= divisor;
      cnt      <= C_W'(N_W - 1);
      busy     <= 1'b1;
      quotient <= '0;
    end else if (busy) begin
      num      <= num << 1;
      rem      <= rem_next;
      quotient <= {quotient[N_W-2:0], ge};
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/gain_restore_16bit.sv
// Gain restore: out1 = in1 * NUM_COEF / DEN_COEF, saturated to signed 16 bits.
// Sign/magnitude split, one multiply, ITER-cycle restoring divide, then
// saturation; valid/ready on both sides, one sample in flight at a time.
//   clk, rst            : clock, asynchronous active-high reset
//   in1, in_valid       : signed input sample and its valid
//   in_ready            : high only while idle
//   out1, out_valid     : signed restored sample, held until out_ready
//   out_ready           : downstream accept
// Optional: define GAIN_RESTORE_ROUND_EN to round half away from zero
// instead of truncating toward zero (latency unchanged).
module gain_restore_16bit
  import anc_pkg::*;
#(
  parameter int unsigned NUM_COEF = ATTEN_DEN,
  parameter int unsigned DEN_COEF = ATTEN_NUM,
  parameter int unsigned ITER     = 30
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] in1,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [SAMPLE_W-1:0] out1,
  output logic                       out_valid,
  input  logic                       out_ready
);

  typedef logic [ITER-1:0] num_t;

  localparam num_t POS_LIM = num_t'(SAT_MAX);
  localparam num_t NEG_LIM = POS_LIM + num_t'(1);
  localparam logic [SAMPLE_W-1:0] DIVISOR = SAMPLE_W'(DEN_COEF);

`ifdef GAIN_RESTORE_ROUND_EN
  localparam num_t BIAS = num_t'(DEN_COEF / 2);
`else
  localparam num_t BIAS = '0;
`endif

  state_t              state;
  logic                sign;
  logic [SAMPLE_W-1:0] mag;
  num_t                num_init;
  num_t                quo;
  logic                div_start;
  logic                div_done;

  // |in1| * NUM_COEF (+ rounding bias) is below 2^30, so the product is kept
  // at ITER bits and every bit is fed through the divider.
  always_comb begin
    num_init = num_t'(mag) * num_t'(NUM_COEF) + BIAS;
  end

  assign div_start = (state == MUL);

  restoring_div_u #(
    .N_W (ITER),
    .D_W (SAMPLE_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (num_init),
    .divisor  (DIVISOR),
    .done     (div_done),
    .quotient (quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sign      <= 1'b0;
      mag       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign     <= in1[SAMPLE_W-1];
            // -(-32768) wraps to 16'h8000, which read unsigned is 32768.
            mag      <= in1[SAMPLE_W-1] ? $unsigned(-in1) : $unsigned(in1);
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          state <= DIV;
        end
        DIV: begin
          if (div_done) begin
            state <= SAT;
          end
        end
        SAT: begin
          if (!sign) begin
            out1 <= (quo > POS_LIM) ? SAT_MAX : $signed(quo[SAMPLE_W-1:0]);
          end else begin
            out1 <= (quo > NEG_LIM) ? SAT_MIN : -$signed(quo[SAMPLE_W-1:0]);
          end
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gain_restore_16bit.sv
module tb_gain_restore_16bit;

  localparam int LATENCY = 32;
`ifdef GAIN_RESTORE_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] in1 = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] out1;
  logic               out_valid;
  logic               out_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gain_restore_16bit dut (
    .clk       (clk),
    .rst       (rst),
    .in1       (in1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out1      (out1),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: x * 32767 / 26123 on magnitudes, truncating (or rounding
  // half away from zero), then clamped to the signed 16-bit range.
  function automatic int model(input int x);
    longint m, q;
    m = (x < 0) ? -x : x;
    q = m * 32767 + (RND ? 26123 / 2 : 0);
    q = q / 26123;
    if (x < 0) return (q > 32768) ? -32768 : int'(-q);
    return (q > 32767) ? 32767 : int'(q);
  endfunction

  task automatic accept(input int x);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_ready", int'(in_ready), 1);
    in1      = 16'(x);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in1      = 16'($urandom);
  endtask

  task automatic wait_out(input string tag);
    int lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
    check({tag, "_latency"}, lat, LATENCY);
  endtask

  task automatic take(input int bp);
    repeat (bp) @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("take_out_valid_low", int'(out_valid), 0);
  endtask

  task automatic run(input string tag, input int x, input int exp, input int bp);
    accept(x);
    wait_out(tag);
    check({tag, "_out1"}, int'(out1), exp);
    take(bp);
  endtask

  initial begin
    int hold_val;
    int seen;

    // Reset while clocks run
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out1", int'(out1), 0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal, saturation and rounding points
    run("nom_23509", 23509, 29488, 0);
    run("nom_26123", 26123, 32767, 1);
    run("nom_m26123", -26123, -32767, 0);
    run("zero", 0, 0, 2);
    run("sat_30000", 30000, 32767, 0);
    run("sat_m32768", -32768, -32768, 0);
    run("sat_32767", 32767, 32767, 0);
    run("round_2", 2, 2 + RND, 0);
    run("round_m2", -2, -2 - RND, 0);
    run("one", 1, 1, 0);
    run("m_one", -1, -1, 0);

    // Backpressure: output held, input blocked, new sample taken one cycle late
    accept(23509);
    wait_out("bp");
    check("bp_out1", int'(out1), 29488);
    @(negedge clk);
    in1      = 16'sd1000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_out1", int'(out1), 29488);
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_hs_valid", int'(out_valid), 0);
    check("bp_hs_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_accepted", int'(in_ready), 0);
    wait_out("bp_next");
    check("bp_next_out1", int'(out1), 1254);
    take(0);

    // Asynchronous reset between edges while an output is held
    accept(23509);
    wait_out("ar");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_in_ready", int'(in_ready), 1);
    check("async_rst_out_valid", int'(out_valid), 0);
    check("async_rst_out1", int'(out1), 0);
    #1;
    rst = 1'b0;

    // Reset during the divide discards the sample
    accept(1000);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("middiv_rst_out_valid", int'(out_valid), 0);
    check("middiv_rst_in_ready", int'(in_ready), 1);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("middiv_no_output", seen, 0);
    run("after_rst_1000", 1000, 1254, 0);

    // Randomized samples against the reference
    for (int i = 0; i < 150; i++) begin
      int x;
      case ($urandom_range(7, 0))
        0:       x = -32768;
        1:       x = 32767;
        2:       x = int'($urandom_range(40, 0)) - 20;
        default: x = int'($urandom_range(65535, 0)) - 32768;
      endcase
      accept(x);
      wait_out("rand");
      hold_val = int'(out1);
      check("rand_out1", hold_val, model(x));
      take(int'($urandom_range(3, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
